iq_decimator: RTL
=================

IQ_DECIMATOR -- requirements
Module: iq_decimator

Interface
REQ-001 SHALL have parameter LOG2_DECIM, default 4, meaning log2 of the decimation ratio R (legal range 0..4).
REQ-002 SHALL have parameter DC_SHIFT, default 8, meaning the DC-tracking time constant 2^DC_SHIFT samples (legal range 4..12).
REQ-003 SHALL have port i_clk  input  1  meaning the single clock.
REQ-004 SHALL have port i_reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port i_sample_stb  input  1  meaning a one-cycle strobe qualifying i_sample_i/i_sample_q.
REQ-006 SHALL have ports i_sample_i, i_sample_q  input  12 each  meaning unsigned offset-binary ADC codes.
REQ-007 SHALL have port o_valid  output  1  meaning an output word is available.
REQ-008 SHALL have port i_ready  input  1  meaning the consumer accepts; a transfer occurs when o_valid and i_ready are both high.
REQ-009 SHALL have ports o_data_i, o_data_q  output  16 each  meaning signed two's-complement decimated I/Q.
REQ-010 SHALL have port o_overrun  output  1  meaning a sticky flag set when a block is dropped.
REQ-011 SHALL have port i_overrun_clr  input  1  meaning a one-cycle pulse that clears o_overrun.

Function
REQ-012 SHALL register each strobed sample as x = code - 2048, giving a 12-bit signed value (4095 -> +2047, 0 -> -2048).
REQ-013 SHALL accumulate R = 2^LOG2_DECIM consecutive converted samples per channel in (12+LOG2_DECIM)-bit signed accumulators; no saturation is needed.
REQ-014 SHALL load the accumulator with the first sample of each block and not add it to the previous contents (integrate-and-dump).
REQ-015 SHALL form the output word as sum sign-extended to 16 bits, then left-shifted by (4-LOG2_DECIM), so full scale is independent of R.
REQ-016 SHALL push the completed block into a 2-entry FIFO the cycle after the R-th sample is accumulated.
REQ-017 SHALL give a latency of 2 cycles from the i_sample_stb of the R-th sample to o_valid (FIFO empty, macro off).
REQ-018 SHALL drive o_data_i/o_data_q from the FIFO head, stable while o_valid is high and i_ready is low.
REQ-019 SHALL drop the new block and set o_overrun when the FIFO is full at push time; the block counter still wraps and the next block starts normally.
REQ-020 SHALL accept the push when a pop and a push occur in the same cycle with the FIFO full.
REQ-021 SHALL leave o_overrun at 1 when i_overrun_clr and a new overrun occur in the same cycle.
REQ-022 SHALL tolerate i_sample_stb on consecutive cycles at full throughput; gaps of any length between strobes are allowed.

Reset
REQ-023 SHALL, when i_reset is high at a clock edge, clear the block counter, accumulators, DC estimates, FIFO and o_overrun.
REQ-024 SHALL drive o_valid=0, o_data_i=0, o_data_q=0 and o_overrun=0 from the first edge with reset high.
REQ-025 SHALL discard any partially accumulated block and all in-flight samples on reset mid-operation; the first sample after reset deasserts starts a new block.

Configuration
REQ-026 SHALL, with macro IQ_DC_REMOVE_EN defined, subtract a per-channel DC estimate before accumulation.
REQ-027 SHALL compute the DC removal as y = x - (dc >>> DC_SHIFT), then update dc += y on each strobe; dc is (12+DC_SHIFT)-bit signed and y is saturated to 12 bits.
REQ-028 SHALL add exactly 1 cycle of latency (total 3) when IQ_DC_REMOVE_EN is defined.
REQ-029 SHALL contain no DC logic when IQ_DC_REMOVE_EN is undefined, with y = x.

Structure
REQ-030 SHALL place the 12-bit sample type, the 16-bit output type and the constant ADC_MIDSCALE=2048 in shared package sdr_pkg.
REQ-031 SHALL implement the output buffer as sub-module iq_fifo2 (2-entry, 32-bit, valid/ready, full/empty).

Verification
REQ-032 SHALL cover: LOG2_DECIM=2, macro off, 4 strobes of I=Q=2048 -> one word I=Q=0, o_valid 2 cycles after the 4th strobe.
REQ-033 SHALL cover: LOG2_DECIM=2, I=4095, Q=0 for 4 strobes -> o_data_i=0x7FF0 (32752), o_data_q=0x8000 (-32768).
REQ-034 SHALL cover: i_ready=0, 12 back-to-back strobes with R=4 -> 2 words held, third block dropped, o_overrun=1; i_overrun_clr -> 0.
REQ-035 SHALL cover: reset asserted after 2 of 4 samples, then 4 samples of code 2049 -> output 0x0010 (4<<2) with no residue from the aborted block.
REQ-036 SHALL cover: IQ_DC_REMOVE_EN defined, DC_SHIFT=4, constant code 3000 for 256 strobes -> |o_data_i| < 64 at the end.
REQ-037 SHALL cover: FIFO full, i_ready=1 in the same cycle as the push -> no overrun, word order preserved.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared sample/output types and ADC conversion helpers for the SDR receive path.
// Pure declarations: no latency, no state.
// No flow control here; consumers handle backpressure.
package sdr_pkg;

  localparam int ADC_MIDSCALE = 2048;

  // Offset-binary ADC code re-centred around zero.
  typedef logic signed [11:0] sample_t;

  // Decimated output word element.
  typedef logic signed [15:0] out_t;

  // One I/Q pair as carried through the output buffer (I in the upper half).
  typedef struct packed {
    out_t i;
    out_t q;
  } iq_word_t;

  // Unsigned offset-binary code -> signed sample (4095 -> +2047, 0 -> -2048).
  function automatic sample_t adc_to_signed(input logic [11:0] code);
    logic [12:0] w_diff;
    w_diff = {1'b0, code} - 13'(ADC_MIDSCALE);
    return sample_t'(w_diff[11:0]);
  endfunction

  // Clamp a 13-bit signed difference into the 12-bit sample range.
  function automatic sample_t sat12(input logic signed [12:0] v);
    if (v > 13'sd2047) begin
      return 12'sh7FF;
    end else if (v < -13'sd2048) begin
      return 12'sh800;
    end else begin
      return sample_t'(v[11:0]);
    end
  endfunction

endpackage

// File: rtl/iq_fifo2.sv
// Two-entry 32-bit I/Q output buffer with valid/ready read side and full/empty status.
// Read data is the registered head entry; a write is visible on the read side the next cycle.
// A write into a full buffer is accepted only when a read happens in the same cycle; otherwise it is ignored.
module iq_fifo2
  import sdr_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_wr_vld,
  input  iq_word_t i_wr_dat,
  input  logic     i_rd_rdy,
  output iq_word_t o_rd_dat,
  output logic     o_full,
  output logic     o_empty
);

  iq_word_t   r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_pop;
  logic w_push;

  // A pop frees a slot in the same cycle, so a full buffer can still take a write.
  assign w_pop  = i_rd_rdy && (r_count != 2'd0);
  assign w_push = i_wr_vld && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy; reset clears data so the read port shows zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_full   = (r_count == 2'd2);
  assign o_empty  = (r_count == 2'd0);

endmodule

// File: rtl/iq_decimator.sv
// I/Q integrate-and-dump decimator by 2^LOG2_DECIM with optional DC removal (macro IQ_DC_REMOVE_EN).
// Latency: 2 cycles from the last strobed sample of a block to o_valid, 3 with IQ_DC_REMOVE_EN.
// Backpressure: 2-word output buffer; a block completing while full and not being read is dropped and o_overrun set.
module iq_decimator
  import sdr_pkg::*;
#(
  parameter int LOG2_DECIM = 4,
  parameter int DC_SHIFT   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sample_stb,
  input  logic [11:0] i_sample_i,
  input  logic [11:0] i_sample_q,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_data_i,
  output logic [15:0] o_data_q,
  output logic        o_overrun,
  input  logic        i_overrun_clr
);

  localparam int R  = 1 << LOG2_DECIM;
  localparam int AW = 12 + LOG2_DECIM;
  localparam int CW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int SH = 4 - LOG2_DECIM;

  if (LOG2_DECIM < 0 || LOG2_DECIM > 4 || DC_SHIFT < 4 || DC_SHIFT > 12) begin : g_param_err
    $error("iq_decimator: LOG2_DECIM must be 0..4 and DC_SHIFT 4..12");
  end

  sample_t r_x_i;
  sample_t r_x_q;
  logic    r_x_vld;

  // Capture and re-centre each strobed ADC sample.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x_i   <= '0;
      r_x_q   <= '0;
      r_x_vld <= 1'b0;
    end else begin
      r_x_vld <= i_sample_stb;
      if (i_sample_stb) begin
        r_x_i <= adc_to_signed(i_sample_i);
        r_x_q <= adc_to_signed(i_sample_q);
      end
    end
  end

  // Sample stream feeding the integrator.
  sample_t w_s_i;
  sample_t w_s_q;
  logic    w_s_vld;

`ifdef IQ_DC_REMOVE_EN
  localparam int DW = 12 + DC_SHIFT;

  logic signed [DW-1:0] r_dc_i;
  logic signed [DW-1:0] r_dc_q;
  sample_t              r_y_i;
  sample_t              r_y_q;
  logic                 r_y_vld;
  sample_t              w_y_i;
  sample_t              w_y_q;

  // y = x - dc/2^DC_SHIFT, clamped; the running sum dc therefore tracks 2^DC_SHIFT times the mean.
  function automatic sample_t dc_sub(input sample_t x, input logic signed [DW-1:0] dc);
    logic signed [DW-1:0] w_est;
    w_est = dc >>> DC_SHIFT;
    return sat12(13'(x) - 13'(w_est));
  endfunction

  assign w_y_i = dc_sub(r_x_i, r_dc_i);
  assign w_y_q = dc_sub(r_x_q, r_dc_q);

  // Remove the DC estimate and fold the corrected sample back into the estimate.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dc_i  <= '0;
      r_dc_q  <= '0;
      r_y_i   <= '0;
      r_y_q   <= '0;
      r_y_vld <= 1'b0;
    end else begin
      r_y_vld <= r_x_vld;
      if (r_x_vld) begin
        r_y_i  <= w_y_i;
        r_y_q  <= w_y_q;
        r_dc_i <= r_dc_i + DW'(w_y_i);
        r_dc_q <= r_dc_q + DW'(w_y_q);
      end
    end
  end

  assign w_s_i   = r_y_i;
  assign w_s_q   = r_y_q;
  assign w_s_vld = r_y_vld;
`else
  assign w_s_i   = r_x_i;
  assign w_s_q   = r_x_q;
  assign w_s_vld = r_x_vld;
`endif

  logic [CW-1:0]        r_cnt;
  logic signed [AW-1:0] r_acc_i;
  logic signed [AW-1:0] r_acc_q;
  logic                 r_push;
  logic                 w_first;
  logic                 w_last;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CW'(R - 1));

  // Integrate-and-dump: first sample of a block loads, the rest add; flag completion for the buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_push  <= 1'b0;
    end else begin
      r_push <= w_s_vld && w_last;
      if (w_s_vld) begin
        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        r_acc_i <= w_first ? AW'(w_s_i) : r_acc_i + AW'(w_s_i);
        r_acc_q <= w_first ? AW'(w_s_q) : r_acc_q + AW'(w_s_q);
      end
    end
  end

  // Sign-extend then scale so full scale does not depend on the decimation ratio.
  out_t     w_out_i;
  out_t     w_out_q;
  iq_word_t w_wr_dat;
  iq_word_t w_rd_dat;
  logic     w_full;
  logic     w_empty;
  logic     w_drop;

  assign w_out_i    = out_t'(r_acc_i) <<< SH;
  assign w_out_q    = out_t'(r_acc_q) <<< SH;
  assign w_wr_dat.i = w_out_i;
  assign w_wr_dat.q = w_out_q;

  iq_fifo2 u_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr_vld (r_push),
    .i_wr_dat (w_wr_dat),
    .i_rd_rdy (i_ready),
    .o_rd_dat (w_rd_dat),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // The buffer refuses a block only when full with no read this cycle.
  assign w_drop = r_push && w_full && !i_ready;

  logic r_overrun;

  // Sticky drop flag; a fresh drop wins over a clear in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_valid   = !w_empty;
  assign o_data_i  = w_rd_dat.i;
  assign o_data_q  = w_rd_dat.q;
  assign o_overrun = r_overrun;

endmodule
